uart_mac_frame_ctrl: RTL and testbench

Command sequencer between the UART byte receiver and the FP32 MAC datapath. It consumes the receiver's byte stream (one-cycle data-valid strobe plus byte) and parses fixed 10-byte frames: SYNC, CMD, A[4], B[4], CHK. Each valid frame is issued to the MAC as one opcode/operand transaction over a valid/ready handshake. Bad frames are reported with a one-cycle error pulse and code.

---
 rtl/uart_ctrl_pkg.sv | 26 ++
 rtl/uart_byte_timer.sv | 33 +++
 rtl/uart_mac_frame_ctrl.sv | 166 ++++++++++++++++
 tb/tb_uart_mac_frame_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART-to-MAC frame sequencer.
// Frame layout: SYNC, CMD, A[4], B[4], CHK.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC = 3'd0,
    GET_CMD   = 3'd1,
    GET_A     = 3'd2,
    GET_B     = 3'd3,
    GET_CHK   = 3'd4,
    ISSUE     = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CHK     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  localparam int FRAME_LEN = 10;

  // Running frame checksum: plain XOR over CMD and the operand bytes.
  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Saturating inter-byte idle counter.
// Expired flags the final count before an idle-timeout.
module uart_byte_timer #(
  parameter int IDLE_TIMEOUT_CLKS = 4340
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(IDLE_TIMEOUT_CLKS);
  localparam logic [W-1:0] LAST = W'(IDLE_TIMEOUT_CLKS - 1);

  logic [W-1:0] count_r;

  // Counter: clear wins, then count up while enabled, holding at LAST.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != LAST)) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/uart_mac_frame_ctrl.sv
// Parses SYNC/CMD/A/B/CHK frames from the UART receiver and issues each good
// frame to the MAC over a valid/ready handshake; bad frames raise an error pulse.
module uart_mac_frame_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE         = 8'hA5,
  parameter int         IDLE_TIMEOUT_CLKS = 4340
) (
  input  logic        i_Clock,
  input  logic        i_Rst_L,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_Byte,
  output logic        o_Op_Valid,
  input  logic        i_Op_Ready,
  output logic [7:0]  o_Op_Cmd,
  output logic [31:0] o_Op_A,
  output logic [31:0] o_Op_B,
  output logic        o_Frame_Err,
  output logic [1:0]  o_Err_Code,
  output logic        o_Busy
);

  localparam logic [1:0] LAST_IDX = 2'(((FRAME_LEN - 2) / 2) - 1);

  state_t      state_r, state_nxt_s;
  logic [1:0]  idx_r;
  logic [7:0]  chk_r, cmd_r;
  logic [31:0] a_r, b_r;
  logic        op_valid_r, frame_err_r, busy_r;
  logic [1:0]  err_code_r, err_code_nxt_s;
  logic        err_pulse_s, last_byte_s, expired_s, timer_en_s, timer_clr_s;

  assign last_byte_s = (idx_r == LAST_IDX);
  assign timer_en_s  = (state_r == GET_CMD) || (state_r == GET_A) ||
                       (state_r == GET_B)   || (state_r == GET_CHK);
  assign timer_clr_s = i_RX_DV || !timer_en_s;

  uart_byte_timer #(.IDLE_TIMEOUT_CLKS(IDLE_TIMEOUT_CLKS)) u_timer (
    .clk     (i_Clock),
    .rst_l   (i_Rst_L),
    .clr     (timer_clr_s),
    .en      (timer_en_s),
    .expired (expired_s)
  );

  // Next-state and error decision; a DV always takes priority over a timeout.
  always_comb begin
    state_nxt_s    = state_r;
    err_pulse_s    = 1'b0;
    err_code_nxt_s = err_code_r;
    case (state_r)
      WAIT_SYNC: begin
        if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) state_nxt_s = GET_CMD;
        else                                     state_nxt_s = WAIT_SYNC;
      end
      GET_CMD, GET_A, GET_B: begin
        if (i_RX_DV) begin
          if (state_r == GET_CMD)  state_nxt_s = GET_A;
          else if (!last_byte_s)   state_nxt_s = state_r;
          else if (state_r == GET_A) state_nxt_s = GET_B;
          else                     state_nxt_s = GET_CHK;
        end else if (expired_s) begin
          state_nxt_s    = WAIT_SYNC;
          err_pulse_s    = 1'b1;
          err_code_nxt_s = ERR_TIMEOUT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      GET_CHK: begin
        if (i_RX_DV) begin
          if (i_RX_Byte == chk_r) begin
            state_nxt_s = ISSUE;
          end else begin
            state_nxt_s    = WAIT_SYNC;
            err_pulse_s    = 1'b1;
            err_code_nxt_s = ERR_CHK;
          end
        end else if (expired_s) begin
          state_nxt_s    = WAIT_SYNC;
          err_pulse_s    = 1'b1;
          err_code_nxt_s = ERR_TIMEOUT;
        end else begin
          state_nxt_s = GET_CHK;
        end
      end
      ISSUE: begin
        // A byte arriving alongside the handshake is simply dropped.
        if (i_Op_Ready) begin
          state_nxt_s = WAIT_SYNC;
        end else if (i_RX_DV) begin
          state_nxt_s    = ISSUE;
          err_pulse_s    = 1'b1;
          err_code_nxt_s = ERR_OVERRUN;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      default: begin
        state_nxt_s = WAIT_SYNC;
      end
    endcase
  end

  // Control registers and the registered status outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r     <= WAIT_SYNC;
      op_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
      err_code_r  <= ERR_NONE;
    end else begin
      state_r     <= state_nxt_s;
      op_valid_r  <= (state_nxt_s == ISSUE);
      busy_r      <= (state_nxt_s != WAIT_SYNC);
      frame_err_r <= err_pulse_s;
      err_code_r  <= err_code_nxt_s;
    end
  end

  // Payload capture; operands load little-endian and only in GET_A / GET_B.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      idx_r <= 2'd0;
      chk_r <= 8'h00;
      cmd_r <= 8'h00;
      a_r   <= 32'h0000_0000;
      b_r   <= 32'h0000_0000;
    end else if (i_RX_DV) begin
      case (state_r)
        WAIT_SYNC: begin
          if (i_RX_Byte == SYNC_BYTE) begin
            chk_r <= 8'h00;
            idx_r <= 2'd0;
          end
        end
        GET_CMD: begin
          cmd_r <= i_RX_Byte;
          chk_r <= chk_update(chk_r, i_RX_Byte);
        end
        GET_A: begin
          a_r[{idx_r, 3'b000} +: 8] <= i_RX_Byte;
          chk_r <= chk_update(chk_r, i_RX_Byte);
          idx_r <= idx_r + 2'd1;
        end
        GET_B: begin
          b_r[{idx_r, 3'b000} +: 8] <= i_RX_Byte;
          chk_r <= chk_update(chk_r, i_RX_Byte);
          idx_r <= idx_r + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_Op_Valid  = op_valid_r;
  assign o_Op_Cmd    = cmd_r;
  assign o_Op_A      = a_r;
  assign o_Op_B      = b_r;
  assign o_Frame_Err = frame_err_r;
  assign o_Err_Code  = err_code_r;
  assign o_Busy      = busy_r;

endmodule

// File: tb/tb_uart_mac_frame_ctrl.sv
// Directed self-checking bench for uart_mac_frame_ctrl.
module tb_uart_mac_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_cmd;
  logic [31:0] op_a, op_b;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_mac_frame_ctrl dut (
    .i_Clock     (clk),
    .i_Rst_L     (rst_l),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .o_Op_Valid  (op_valid),
    .i_Op_Ready  (op_ready),
    .o_Op_Cmd    (op_cmd),
    .o_Op_A      (op_a),
    .o_Op_B      (op_b),
    .o_Frame_Err (frame_err),
    .o_Err_Code  (err_code),
    .o_Busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle DV; returns 1ns after the edge that sampled the byte.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_dv = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a,
                            input logic [31:0] b, input logic [7:0] flip);
    logic [7:0] c;
    c = cmd ^ a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24]
            ^ b[7:0] ^ b[15:8] ^ b[23:16] ^ b[31:24] ^ flip;
    send_byte(8'hA5);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
    send_byte(c);
  endtask

  initial begin
    rst_l = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; op_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, op_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_code",  {30'd0, err_code}, 32'd0);
    check("rst_a",     op_a, 32'd0);
    rst_l = 1'b1;

    // Good frame, checksum FE, MAC ready.
    send_frame(8'h01, 32'h3F80_0000, 32'h4000_0000, 8'h00);
    check("f1_valid", {31'd0, op_valid}, 32'd1);
    check("f1_cmd",   {24'd0, op_cmd}, 32'h01);
    check("f1_a",     op_a, 32'h3F80_0000);
    check("f1_b",     op_b, 32'h4000_0000);
    check("f1_err",   {31'd0, frame_err}, 32'd0);
    @(posedge clk); #1;
    check("f1_valid_clr", {31'd0, op_valid}, 32'd0);
    check("f1_busy_clr",  {31'd0, busy}, 32'd0);

    // Bad checksum.
    send_frame(8'h01, 32'h3F80_0000, 32'h4000_0000, 8'h01);
    check("chk_err",   {31'd0, frame_err}, 32'd1);
    check("chk_code",  {30'd0, err_code}, 32'd1);
    check("chk_valid", {31'd0, op_valid}, 32'd0);
    check("chk_busy",  {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("chk_pulse_end", {31'd0, frame_err}, 32'd0);
    check("chk_code_hold", {30'd0, err_code}, 32'd1);

    // Timeout: fires on the 4340th edge after the last DV, not before.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    repeat (4339) @(posedge clk);
    #1;
    check("to_early_err",  {31'd0, frame_err}, 32'd0);
    check("to_early_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("to_err",  {31'd0, frame_err}, 32'd1);
    check("to_code", {30'd0, err_code}, 32'd2);
    check("to_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h03, 32'hC0A0_0000, 32'h0000_0001, 8'h00);
    check("to_next_valid", {31'd0, op_valid}, 32'd1);
    check("to_next_a",     op_a, 32'hC0A0_0000);
    check("to_next_b",     op_b, 32'h0000_0001);
    @(posedge clk); #1;

    // Overrun while stalled; SYNC value inside payload is plain data.
    op_ready = 1'b0;
    send_frame(8'h02, 32'h1234_5678, 32'hA5A5_A5A5, 8'h00);
    check("ov_valid", {31'd0, op_valid}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("ov_hold", {31'd0, op_valid}, 32'd1);
    send_byte(8'h55);
    check("ov_err",   {31'd0, frame_err}, 32'd1);
    check("ov_code",  {30'd0, err_code}, 32'd3);
    check("ov_valid2", {31'd0, op_valid}, 32'd1);
    check("ov_cmd",   {24'd0, op_cmd}, 32'h02);
    check("ov_a",     op_a, 32'h1234_5678);
    check("ov_b",     op_b, 32'hA5A5_A5A5);
    op_ready = 1'b1;
    @(posedge clk); #1;
    check("ov_hs_valid", {31'd0, op_valid}, 32'd0);
    check("ov_hs_busy",  {31'd0, busy}, 32'd0);
    check("ov_hs_err",   {31'd0, frame_err}, 32'd0);

    // Leading junk before SYNC.
    send_byte(8'h00);
    check("junk0_busy", {31'd0, busy}, 32'd0);
    send_byte(8'hFF);
    check("junkff_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h12);
    check("junk12_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h04, 32'h4049_0FDB, 32'hBF80_0000, 8'h00);
    check("junk_valid", {31'd0, op_valid}, 32'd1);
    check("junk_cmd",   {24'd0, op_cmd}, 32'h04);
    check("junk_b",     op_b, 32'hBF80_0000);
    @(posedge clk); #1;
    check("junk_done", {31'd0, op_valid}, 32'd0);

    // Asynchronous reset in GET_B.
    send_byte(8'hA5);
    send_byte(8'h07);
    for (int i = 0; i < 4; i++) send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_l = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_cmd",  {24'd0, op_cmd}, 32'd0);
    check("arst_a",    op_a, 32'd0);
    check("arst_b",    op_b, 32'd0);
    check("arst_err",  {29'd0, frame_err, err_code}, 32'd0);
    @(posedge clk); #1;
    rst_l = 1'b1;
    send_frame(8'h08, 32'h0000_00FF, 32'h8000_0000, 8'h00);
    check("post_rst_valid", {31'd0, op_valid}, 32'd1);
    check("post_rst_a",     op_a, 32'h0000_00FF);
    check("post_rst_err",   {29'd0, frame_err, err_code}, 32'd0);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
